// File: rtl/imem_boot.sv
// Instruction memory with a boot-time program loader and a one-cycle-latency
// fetch port. IDLE/RUN serve fetches; LOAD streams program words into the array.
module imem_boot #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              mem_clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              flush,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Load handshake: a word transfers on any edge where load_valid && load_ready.
  // load_ready is high for the whole LOAD state and never depends on load_valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q;
  logic              accept;
  logic              load_end;
  logic [DATA_W-1:0] mem [DEPTH];

  assign accept    = load_valid && load_ready;
  // The last array slot (wptr all ones) ends the load even without load_last.
  assign load_end  = accept && (load_last || (&wptr_q));
  assign state_dbg = state_q;

  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE, RUN: if (load_start) state_d = LOAD;
      LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        if (load_end) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      load_count  <= '0;
      load_done   <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_done <= 1'b0;
      if (state_q != LOAD && load_start) begin
        // Entering LOAD invalidates the fetched word so the pipeline refetches.
        wptr_q      <= '0;
        load_count  <= '0;
        rdata_valid <= 1'b0;
      end else if (state_q == LOAD) begin
        rdata_valid <= 1'b0;
        if (flush) rdata <= '0;
        if (accept) begin
          wptr_q     <= wptr_q + 1'b1;
          load_count <= load_count + 1'b1;
          load_done  <= load_end;
        end
      end else if (flush) begin
        rdata       <= '0;
        rdata_valid <= 1'b0;
      end else if (fetch_en) begin
        rdata       <= mem[fetch_addr];
        rdata_valid <= 1'b1;
      end
    end
  end

  // The array has no reset so a preloaded program survives rst.
  always_ff @(posedge mem_clk) begin
    if (accept) mem[wptr_q] <= load_data;
  end

endmodule
